// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S receive-side framing detector.
// Holds the detector FSM state encoding, configuration limits and the
// expected half-period length calculation.
package i2s_pkg;

  // Detector FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } ws_det_state_e;

  // Configuration limits: up to 32 bits per word, up to 8 words per half.
  localparam int unsigned MAX_WORD_SIZE = 32;
  localparam int unsigned MAX_WORD_NUM  = 8;
  localparam int unsigned WORD_SIZE_W   = $clog2(MAX_WORD_SIZE);
  localparam int unsigned WORD_NUM_W    = $clog2(MAX_WORD_NUM);

  // Expected bits per WS half-period from the minus-one encoded config.
  // The worst case is 32 * 8 = 256, so 32-bit arithmetic never overflows.
  function automatic int unsigned calc_exp_len(
    input logic [WORD_SIZE_W-1:0] size_m1,
    input logic [WORD_NUM_W-1:0]  num_m1
  );
    return (32'(size_m1) + 32'd1) * (32'(num_m1) + 32'd1);
  endfunction

endpackage

// File: rtl/i2s_edge_sync.sv
// Multi-stage synchroniser for one asynchronous pin plus rising-edge
// detect. rise_o is high for one clk_i cycle once the synchronised value
// goes 0->1; it is combinational from two flops of this module.
module i2s_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the pin through the synchroniser and remember the last synced value.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_ws_detect.sv
// I2S receive-side SCK/WS framing detector.
// Oversamples external SCK/WS in the clk_i domain, strobes each SCK rising
// edge, measures every WS half-period in bits and compares it with the
// configured word size * word count. Reports lock and a sticky error.
// Optional build macro I2S_WS_DETECT_TIMEOUT_EN adds a TO_W-bit watchdog that
// drops back to SEEK when SCK stalls; without it a stalled SCK freezes the FSM.
module i2s_ws_detect
  import i2s_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 9,
  parameter int unsigned LOCK_HALVES = 2,
  parameter int unsigned TO_W        = 12
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   en_i,
  input  logic                   sck_i,
  input  logic                   ws_i,
  input  logic [WORD_SIZE_W-1:0] cfg_word_size_i,
  input  logic [WORD_NUM_W-1:0]  cfg_word_num_i,
  input  logic                   err_clr_i,
  output logic                   bit_strobe_o,
  output logic                   bit_ws_o,
  output logic                   frame_start_o,
  output logic [CNT_W-1:0]       half_len_o,
  output logic                   locked_o,
  output logic                   err_o
);

  localparam int unsigned      M_W     = $clog2(LOCK_HALVES + 1);
  localparam logic [M_W-1:0]   LOCK_M  = M_W'(LOCK_HALVES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Pin synchronisation
  // ---------------------------------------------------------------------------
  logic sck_sync_unused;
  logic sck_rise;
  logic ws_sync;
  logic ws_rise_unused;

  i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (sck_i),
    .sync_o (sck_sync_unused),
    .rise_o (sck_rise)
  );

  i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ws_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (ws_i),
    .sync_o (ws_sync),
    .rise_o (ws_rise_unused)
  );

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  ws_det_state_e    state_q, state_d;
  logic             ws_q, ws_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_len_q, half_len_d;
  logic [M_W-1:0]   m_q, m_d;
  logic             strobe_q, strobe_d;
  logic             frame_q, frame_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             err_set;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  logic             active;
  logic             act_rise;
  logic             wsx;
  logic [CNT_W-1:0] exp_len;
  logic             cnt_sat;
  logic             len_ok;
  logic             sat_now;
  logic             timeout;

  // Strobes only while enabled and out of IDLE.
  assign active   = en_i && (state_q != IDLE);
  assign act_rise = active && sck_rise;
  assign wsx      = act_rise && (ws_sync != ws_q);
  assign exp_len  = CNT_W'(calc_exp_len(cfg_word_size_i, cfg_word_num_i));
  // A saturated count never matches, even if exp_len happens to be all-ones.
  assign cnt_sat  = &cnt_q;
  assign len_ok   = (cnt_q == exp_len) && !cnt_sat;
  // This rise pushes the count into saturation without a WS transition.
  assign sat_now  = act_rise && !wsx && (cnt_q == (CNT_MAX - CNT_W'(1)));

  // WS is captured on every synchronised SCK rise, so re-enabling never sees
  // a stale WS and reports a spurious transition.
  assign ws_d = sck_rise ? ws_sync : ws_q;

`ifdef I2S_WS_DETECT_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;

  assign timeout = active && !act_rise && (&to_q);

  // Watchdog: count cycles since the last rise while out of IDLE.
  always_comb begin
    to_d = '0;
    if (active && !act_rise && !(&to_q)) begin
      to_d = to_q + TO_W'(1);
    end
  end

  // Watchdog register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  // No watchdog in this build; TO_W stays so both builds share one parameter list.
  logic [TO_W-1:0] to_unused;
  assign to_unused = '0;
  assign timeout   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = IDLE;
    end else if (timeout) begin
      state_d = SEEK;
    end else begin
      unique case (state_q)
        IDLE:    state_d = SEEK;
        SEEK:    if (wsx) state_d = MEASURE;
        MEASURE: if (wsx && len_ok && ((m_q + M_W'(1)) == LOCK_M)) state_d = LOCKED;
        LOCKED:  if ((wsx && !len_ok) || sat_now) state_d = MEASURE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output and datapath next values: strobes, bit counter, match count, lock, error.
  always_comb begin
    strobe_d   = 1'b0;
    frame_d    = 1'b0;
    cnt_d      = cnt_q;
    half_len_d = half_len_q;
    m_d        = m_q;
    locked_d   = locked_q;
    err_set    = 1'b0;

    if (!en_i) begin
      // Disable clears measurement progress; err and half_len are held.
      cnt_d    = '0;
      m_d      = '0;
      locked_d = 1'b0;
    end else begin
      if (act_rise) begin
        strobe_d = 1'b1;
        frame_d  = wsx && !ws_sync;
        if (wsx) begin
          half_len_d = cnt_q;
          cnt_d      = CNT_W'(1);
        end else if (!cnt_sat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      unique case (state_q)
        SEEK: begin
          if (wsx) m_d = '0;
        end
        MEASURE: begin
          if (wsx) begin
            if (len_ok) begin
              m_d = m_q + M_W'(1);
              if ((m_q + M_W'(1)) == LOCK_M) locked_d = 1'b1;
            end else begin
              m_d = '0;
            end
          end
        end
        LOCKED: begin
          if ((wsx && !len_ok) || sat_now) begin
            err_set  = 1'b1;
            locked_d = 1'b0;
            m_d      = '0;
          end
        end
        default: ;
      endcase

      if (timeout) begin
        locked_d = 1'b0;
        m_d      = '0;
        if (state_q == LOCKED) err_set = 1'b1;
      end
    end

    // A new error wins over a clear in the same cycle.
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ws_q       <= 1'b0;
      cnt_q      <= '0;
      half_len_q <= '0;
      m_q        <= '0;
      strobe_q   <= 1'b0;
      frame_q    <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ws_q       <= ws_d;
      cnt_q      <= cnt_d;
      half_len_q <= half_len_d;
      m_q        <= m_d;
      strobe_q   <= strobe_d;
      frame_q    <= frame_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign bit_strobe_o  = strobe_q;
  assign bit_ws_o      = ws_q;
  assign frame_start_o = frame_q;
  assign half_len_o    = half_len_q;
  assign locked_o      = locked_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_i2s_ws_detect.sv
// Directed bench for i2s_ws_detect: reset values, strobe latency, lock,
// mismatch, saturation, error set/clear priority, SCK stall and enable drop.
// Define I2S_WS_DETECT_TIMEOUT_EN to exercise the watchdog build (TO_W=6).
module tb_i2s_ws_detect;

  localparam int unsigned CNT_W = 9;
`ifdef I2S_WS_DETECT_TIMEOUT_EN
  localparam int unsigned TO_W = 6;
`else
  localparam int unsigned TO_W = 12;
`endif

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic             en_i;
  logic             sck_i;
  logic             ws_i;
  logic [4:0]       cfg_word_size_i;
  logic [2:0]       cfg_word_num_i;
  logic             err_clr_i;
  logic             bit_strobe_o;
  logic             bit_ws_o;
  logic             frame_start_o;
  logic [CNT_W-1:0] half_len_o;
  logic             locked_o;
  logic             err_o;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int strobe_cnt = 0;
  int frame_cnt  = 0;
  int s0, f0;

  i2s_ws_detect #(
    .SYNC_STAGES (2),
    .CNT_W       (CNT_W),
    .LOCK_HALVES (2),
    .TO_W        (TO_W)
  ) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .en_i            (en_i),
    .sck_i           (sck_i),
    .ws_i            (ws_i),
    .cfg_word_size_i (cfg_word_size_i),
    .cfg_word_num_i  (cfg_word_num_i),
    .err_clr_i       (err_clr_i),
    .bit_strobe_o    (bit_strobe_o),
    .bit_ws_o        (bit_ws_o),
    .frame_start_o   (frame_start_o),
    .half_len_o      (half_len_o),
    .locked_o        (locked_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Count strobes and frame starts, sampled away from the active edge.
  always @(negedge clk_i) begin
    if (bit_strobe_o)  strobe_cnt = strobe_cnt + 1;
    if (frame_start_o) frame_cnt  = frame_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total_cnt = total_cnt + 1;
    if (got !== want) begin
      bad_cnt = bad_cnt + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // One SCK bit at clk/8: WS changes with SCK low, SCK rises after 4 clk.
  // With clr_at_edge the err_clr pulse lands on the cycle the rise is evaluated.
  task automatic send_bit(input logic ws, input logic clr_at_edge);
    sck_i = 1'b0;
    ws_i  = ws;
    repeat (4) @(negedge clk_i);
    sck_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_i);
      err_clr_i = clr_at_edge && (i == 2);
    end
    err_clr_i = 1'b0;
  endtask

  task automatic send_half(input logic ws, input int n);
    for (int i = 0; i < n; i++) send_bit(ws, 1'b0);
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rstn_i          = 1'b0;
    en_i            = 1'b0;
    sck_i           = 1'b0;
    ws_i            = 1'b0;
    cfg_word_size_i = 5'd15;
    cfg_word_num_i  = 3'd1;
    err_clr_i       = 1'b0;
    repeat (3) @(negedge clk_i);

    // Reset state.
    check("rst_strobe",   32'(bit_strobe_o),  32'd0);
    check("rst_bit_ws",   32'(bit_ws_o),      32'd0);
    check("rst_frame",    32'(frame_start_o), 32'd0);
    check("rst_half_len", 32'(half_len_o),    32'd0);
    check("rst_locked",   32'(locked_o),      32'd0);
    check("rst_err",      32'(err_o),         32'd0);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Strobe latency: pin edge half a cycle before posedge 1, pulse after posedge 3.
    en_i = 1'b1;
    repeat (3) @(negedge clk_i);
    ws_i  = 1'b1;
    sck_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_i);
      #1;
      check($sformatf("lat_strobe_%0d", k), 32'(bit_strobe_o), (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) begin
        check("lat_bit_ws", 32'(bit_ws_o),      32'd1);
        check("lat_frame",  32'(frame_start_o), 32'd0);
      end
    end
    @(negedge clk_i);
    sck_i = 1'b0;
    en_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    en_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Lock: 16-bit x 2 words -> 32 bits per half; locks on 2nd matching wsx.
    s0 = strobe_cnt;
    f0 = frame_cnt;
    send_half(1'b1, 3);
    send_half(1'b0, 32);
    check("lock_h1_locked", 32'(locked_o), 32'd0);
    send_half(1'b1, 32);
    check("lock_h2_len",    32'(half_len_o), 32'd32);
    check("lock_h2_locked", 32'(locked_o),   32'd0);
    send_half(1'b0, 32);
    check("lock_h3_locked", 32'(locked_o),   32'd1);
    check("lock_h3_len",    32'(half_len_o), 32'd32);
    check("lock_h3_err",    32'(err_o),      32'd0);
    send_half(1'b1, 32);
    check("lock_h4_locked", 32'(locked_o),   32'd1);
    check("lock_strobes",   32'(strobe_cnt - s0), 32'd131);
    check("lock_frames",    32'(frame_cnt - f0),  32'd2);

    // Mismatch while locked: a 31-bit half.
    send_half(1'b0, 31);
    check("mis_pre_locked", 32'(locked_o), 32'd1);
    send_half(1'b1, 32);
    check("mis_err",    32'(err_o),      32'd1);
    check("mis_locked", 32'(locked_o),   32'd0);
    check("mis_len",    32'(half_len_o), 32'd31);
    send_half(1'b0, 32);
    check("relock_1", 32'(locked_o), 32'd0);
    send_half(1'b1, 32);
    check("relock_2",     32'(locked_o), 32'd1);
    check("relock_err",   32'(err_o),    32'd1);
    pulse_clr();
    check("clr_err", 32'(err_o), 32'd0);

    // Set and clear in the same cycle: set wins.
    send_half(1'b0, 31);
    send_bit(1'b1, 1'b1);
    check("setclr_err",    32'(err_o),    32'd1);
    check("setclr_locked", 32'(locked_o), 32'd0);
    send_half(1'b1, 31);
    pulse_clr();
    check("setclr_clr", 32'(err_o), 32'd0);
    send_half(1'b0, 32);
    send_half(1'b1, 32);
    check("setclr_relock", 32'(locked_o), 32'd1);

    // Saturation: 510 bits still locked, the 511th saturates.
    send_half(1'b0, 510);
    check("sat_510_locked", 32'(locked_o), 32'd1);
    check("sat_510_err",    32'(err_o),    32'd0);
    send_half(1'b0, 90);
    check("sat_err",    32'(err_o),      32'd1);
    check("sat_locked", 32'(locked_o),   32'd0);
    check("sat_len_held", 32'(half_len_o), 32'd32);
    send_half(1'b1, 32);
    check("sat_len", 32'(half_len_o), 32'd511);
    pulse_clr();
    // Mismatch in MEASURE resets matching but never flags err.
    send_half(1'b0, 20);
    send_half(1'b1, 32);
    check("meas_mis_err", 32'(err_o),      32'd0);
    check("meas_mis_len", 32'(half_len_o), 32'd20);
    send_half(1'b0, 32);
    check("meas_relock_1", 32'(locked_o), 32'd0);
    send_half(1'b1, 32);
    check("meas_relock_2", 32'(locked_o), 32'd1);

    // SCK stall while locked.
    repeat (40) @(negedge clk_i);
    check("stall_40_locked", 32'(locked_o), 32'd1);
    repeat (40) @(negedge clk_i);
`ifdef I2S_WS_DETECT_TIMEOUT_EN
    check("to_locked", 32'(locked_o), 32'd0);
    check("to_err",    32'(err_o),    32'd1);
    pulse_clr();
`else
    check("stall_80_locked", 32'(locked_o), 32'd1);
    check("stall_80_err",    32'(err_o),    32'd0);
`endif
    send_half(1'b0, 32);
    send_half(1'b1, 32);
    send_half(1'b0, 32);
    check("stall_relock", 32'(locked_o), 32'd1);

    // Enable drop mid-frame with err set.
    send_half(1'b1, 31);
    send_half(1'b0, 32);
    send_half(1'b1, 32);
    send_half(1'b0, 16);
    check("en_pre_locked", 32'(locked_o), 32'd1);
    check("en_pre_err",    32'(err_o),    32'd1);
    en_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("en_locked", 32'(locked_o),   32'd0);
    check("en_err",    32'(err_o),      32'd1);
    check("en_len",    32'(half_len_o), 32'd32);
    @(negedge clk_i);
    s0 = strobe_cnt;
    f0 = frame_cnt;
    send_half(1'b1, 8);
    check("en_no_strobes", 32'(strobe_cnt - s0), 32'd0);
    check("en_no_frames",  32'(frame_cnt - f0),  32'd0);

    // Asynchronous reset clears held state immediately.
    rstn_i = 1'b0;
    #1;
    check("arst_err", 32'(err_o),      32'd0);
    check("arst_len", 32'(half_len_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/i2s_ws_detect.md
Name: i2s_ws_detect

Overview:
Receive-side companion to the I2S SCK/WS generator. It oversamples an externally driven SCK/WS pair in the uDMA system clock domain and detects SCK rising edges and WS transitions. It measures the number of bits in each WS half-period and checks that count against the configured word size and word count. It reports per-bit strobes, frame starts, lock status and a sticky framing error to the I2S channel logic and the register file.

Parameters:
SYNC_STAGES, 2, synchroniser depth for sck_i and ws_i (min 2)
CNT_W, 9, width of the bit counter; holds up to 32 bits x 8 words = 256
LOCK_HALVES, 2, consecutive matching WS half-periods required to assert lock (min 1)
TO_W, 12, watchdog counter width (used only with the optional feature)

Ports:
clk_i  in  1  system clock; must run at least 4x SCK
rstn_i  in  1  asynchronous active-low reset
en_i  in  1  detector enable, level-sensitive
sck_i  in  1  external SCK, asynchronous to clk_i
ws_i  in  1  external WS, asynchronous to clk_i
cfg_word_size_i  in  5  bits per word minus 1
cfg_word_num_i  in  3  words per WS half-period minus 1
err_clr_i  in  1  single-cycle pulse; clears err_o
bit_strobe_o  out  1  one-cycle pulse per detected SCK rising edge
bit_ws_o  out  1  WS value sampled at that edge; valid with bit_strobe_o
frame_start_o  out  1  one-cycle pulse, coincident with bit_strobe_o, when sampled WS goes 1->0
half_len_o  out  CNT_W  bit count of the last completed half-period
locked_o  out  1  framing matches configuration
err_o  out  1  sticky framing error

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters and synchroniser flops 0.
- Synchronisation: sck_i and ws_i each pass through SYNC_STAGES flops. One further register holds the previous synced SCK value.
- SCK rising edge (rise): synced SCK = 1 and previous = 0. bit_strobe_o goes high SYNC_STAGES+1 clk_i cycles after the pin edge, for exactly 1 cycle.
- WS sampling: synced WS is captured on each rise into ws_q; bit_ws_o = ws_q.
- WS transition (wsx): on a rise, the newly sampled WS differs from ws_q.
- Expected length: exp = (cfg_word_size_i+1)*(cfg_word_num_i+1), computed at CNT_W bits with no overflow.
- Counter cnt:
  - On a rise with wsx: the completed half-period length is cnt; half_len_o <= cnt; cnt <= 1.
  - On a rise without wsx: cnt <= cnt+1, saturating at all-ones.
  - A saturated cnt always compares as a mismatch.
- FSM states IDLE, SEEK, MEASURE, LOCKED:
  - IDLE: while en_i=0 the FSM stays in IDLE and emits no strobes. en_i 0->1 moves to SEEK.
  - SEEK: rises produce strobes but no length is evaluated. The first wsx moves to MEASURE with cnt=1 and match counter m=0.
  - MEASURE, on wsx:
    - cnt==exp: m++. When m reaches LOCK_HALVES, move to LOCKED and assert locked_o on the same cycle.
    - cnt!=exp: m=0 and stay in MEASURE. err_o is not set.
  - LOCKED, on wsx with cnt!=exp: err_o <= 1, locked_o <= 0, m=0, move to MEASURE.
  - LOCKED, cnt reaching saturation before a wsx: same handling as a mismatch.
- frame_start_o: a rise with wsx and new WS=0. It pulses in every state except IDLE.
- en_i deassertion: synchronous move to IDLE. Clears cnt, m, locked_o and the strobes. err_o and half_len_o are held.
- Configuration changes while LOCKED take effect at the next wsx compare. A resulting mismatch flags err_o.
- err_clr_i: clears err_o. If a set and a clear occur in the same cycle, the set wins.
- Reset asserted mid-frame: immediate return to reset values; no partial state survives.

Optional Feature:
Macro I2S_WS_DETECT_TIMEOUT_EN.
- Defined:
  - A TO_W-bit watchdog counts clk_i cycles since the last rise in SEEK, MEASURE and LOCKED, and is cleared on every rise.
  - When it reaches all-ones, the FSM returns to SEEK, locked_o drops and m=0.
  - If the FSM was in LOCKED at timeout, err_o is also set.
- Undefined: no watchdog logic; a stalled SCK leaves the FSM in its current state indefinitely.

Decomposition:
- Shared package i2s_pkg holds:
  - the FSM state enum ws_det_state_e (IDLE, SEEK, MEASURE, LOCKED);
  - localparams for the maximum word size (32) and maximum word count (8);
  - a function computing exp.
- One sub-module, i2s_edge_sync: a parameterised SYNC_STAGES synchroniser plus rise detect. It is instantiated for SCK (with rise output) and for WS (synced value only).

Test Plan:
- Lock: cfg 16-bit, 2 words (size=15, num=1); SCK at clk/8; 4 halves of 32 bits -> half_len_o=32; locked_o asserts at the 2nd matching wsx; err_o=0; frame_start_o once per frame.
- Mismatch: locked with exp=32; inject a 31-bit half -> err_o=1 and locked_o=0 on that wsx; half_len_o=31; relock after 2 correct halves; err_o stays 1 until err_clr_i.
- Strobe latency: single SCK rise -> bit_strobe_o pulses exactly SYNC_STAGES+1=3 clk later for 1 cycle; bit_ws_o equals the WS level held at that rise.
- Saturation: WS held constant for 600 SCK edges while LOCKED -> cnt saturates at 511, err_o=1, locked_o=0.
- Enable/clear: en_i dropped mid-frame -> next cycle locked_o=0 with no strobes and err_o held; err_clr_i and an error on the same cycle -> err_o=1.
- Timeout (macro defined, TO_W=6): stop SCK while LOCKED -> after 63 clk, locked_o=0, err_o=1, FSM in SEEK.
